// File: rtl/ifu_aligner_if.sv
// Fetch-side and decode-side handshake bundle of the instruction aligner.
// master = aligner, slave = memory/decode environment.
interface ifu_aligner_if;
    logic        req_valid_o;
    logic [63:0] req_addr_o;
    logic        req_ready_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        branch_i;
    logic [63:0] branch_target_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        is_compressed_o;
    logic        misaligned_o;

    modport master (
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o,
               is_compressed_o, misaligned_o,
        input  req_ready_i, rvalid_i, rdata_i, branch_i, branch_target_i,
               inst_ready_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o,
               is_compressed_o, misaligned_o,
        output req_ready_i, rvalid_i, rdata_i, branch_i, branch_target_i,
               inst_ready_i
    );
endinterface

// File: rtl/ifu_aligner.sv
// Instruction fetch aligner: 32-bit fetches into a 3-parcel buffer, one instruction per handshake.
// Define RVC_EN to recognise 16-bit parcels; otherwise a misaligned redirect raises a marker.
module ifu_aligner #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic         clock,
    input  logic         reset,
    ifu_aligner_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} fsm_t;

    fsm_t        state_reg, state_next;
    logic [15:0] slot_reg [3];
    logic [15:0] slot_next [3];
    logic [15:0] s_pop [3];
    logic [15:0] par [2];
    logic [1:0]  count_reg, count_next;
    logic [63:0] head_pc_reg, head_pc_next;
    logic [63:0] fetch_pc_reg, fetch_pc_next;
    logic        drop_reg, drop_next;
    logic        skip_lo_reg, skip_lo_next;
    logic        mis_reg, mis_next;
    logic        req_valid_reg, req_valid_next;
    logic [63:0] req_addr_reg;

    logic        head_c;
    logic        inst_valid;
    logic [31:0] inst_word;
    logic        consume;
    logic        accept;
    logic        append;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [1:0]  cnt_pop;
    logic [1:0]  count_app;

`ifdef RVC_EN
    assign head_c = (slot_reg[0][1:0] != 2'b11);
`else
    assign head_c = 1'b0;
`endif

    always_comb begin
        inst_valid = mis_reg || ((count_reg != 2'd0) && (head_c || (count_reg >= 2'd2)));
        if (mis_reg) begin
            inst_word = 32'h0;
        end else if (head_c) begin
            inst_word = {16'h0, slot_reg[0]};
        end else begin
            inst_word = {slot_reg[1], slot_reg[0]};
        end
    end

    assign consume = inst_valid && bus.inst_ready_i;
    assign accept  = req_valid_reg && bus.req_ready_i;
    assign pop_n   = (consume && !mis_reg) ? (head_c ? 2'd1 : 2'd2) : 2'd0;

    assign bus.inst_valid_o    = inst_valid;
    assign bus.inst_o          = inst_valid ? inst_word : 32'h0;
    assign bus.pc_o            = inst_valid ? head_pc_reg : 64'h0;
    assign bus.is_compressed_o = inst_valid && head_c && !mis_reg;
    assign bus.misaligned_o    = mis_reg;
    assign bus.req_valid_o     = req_valid_reg;
    assign bus.req_addr_o      = req_addr_reg;

    always_comb begin
        state_next    = state_reg;
        head_pc_next  = head_pc_reg + {61'd0, pop_n, 1'b0};
        fetch_pc_next = fetch_pc_reg;
        drop_next     = drop_reg;
        skip_lo_next  = skip_lo_reg;
        mis_next      = mis_reg;
        cnt_pop       = count_reg - pop_n;

        // Pop first: shift remaining parcels down to slot 0.
        for (int i = 0; i < 3; i++) begin
            s_pop[i] = 16'h0;
            if (i + int'(pop_n) < 3) begin
                s_pop[i] = slot_reg[i + int'(pop_n)];
            end
        end

        if (skip_lo_reg) begin
            par[0] = bus.rdata_i[31:16];
            par[1] = 16'h0;
            push_n = 2'd1;
        end else begin
            par[0] = bus.rdata_i[15:0];
            par[1] = bus.rdata_i[31:16];
            push_n = 2'd2;
        end

        append    = bus.rvalid_i && !drop_reg && (state_reg == WAIT);
        count_app = cnt_pop + (append ? push_n : 2'd0);
        count_next = count_app;

        // Append after the pop, behind whatever parcels survived.
        for (int i = 0; i < 3; i++) begin
            slot_next[i] = 16'h0;
            if (i < int'(cnt_pop)) begin
                slot_next[i] = s_pop[i];
            end else if (append && (i - int'(cnt_pop) < int'(push_n))) begin
                slot_next[i] = par[i - int'(cnt_pop)];
            end
        end

        if (consume && mis_reg) begin
            mis_next = 1'b0;
        end
        if (bus.rvalid_i && drop_reg) begin
            drop_next = 1'b0;
        end
        if (append) begin
            skip_lo_next = 1'b0;
        end

        case (state_reg)
            REQ: begin
                if (accept) begin
                    state_next    = WAIT;
                    fetch_pc_next = fetch_pc_reg + 64'd4;
                end
            end
            WAIT: begin
                if (append) begin
                    state_next = (count_app <= 2'd1) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (count_app <= 2'd1) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase

        // Redirect overrides consume and append. drop tracks whether a response
        // to an old-path request is still in flight after this edge.
        if (bus.branch_i) begin
            for (int i = 0; i < 3; i++) begin
                slot_next[i] = 16'h0;
            end
            count_next    = 2'd0;
            head_pc_next  = {bus.branch_target_i[63:1], 1'b0};
            fetch_pc_next = {bus.branch_target_i[63:2], 2'b00};
            skip_lo_next  = bus.branch_target_i[1];
            drop_next     = (((state_reg == WAIT) || drop_reg) && !bus.rvalid_i) || accept;
            state_next    = REQ;
`ifdef RVC_EN
            mis_next      = 1'b0;
`else
            mis_next      = bus.branch_target_i[1];
`endif
        end

        req_valid_next = (state_next == REQ) && !mis_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= REQ;
            count_reg     <= 2'd0;
            head_pc_reg   <= RESET_PC;
            fetch_pc_reg  <= RESET_PC;
            drop_reg      <= 1'b0;
            skip_lo_reg   <= 1'b0;
            mis_reg       <= 1'b0;
            req_valid_reg <= 1'b0;
            req_addr_reg  <= 64'h0;
            for (int i = 0; i < 3; i++) begin
                slot_reg[i] <= 16'h0;
            end
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            head_pc_reg   <= head_pc_next;
            fetch_pc_reg  <= fetch_pc_next;
            drop_reg      <= drop_next;
            skip_lo_reg   <= skip_lo_next;
            mis_reg       <= mis_next;
            req_valid_reg <= req_valid_next;
            req_addr_reg  <= req_valid_next ? fetch_pc_next : 64'h0;
            for (int i = 0; i < 3; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end
endmodule

// File: tb/tb_ifu_aligner.sv
// Randomised bench for ifu_aligner: hashed memory image, random latency/stalls/redirects,
// scoreboard of the expected instruction stream walked from the memory image.
module tb_ifu_aligner;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int RUN_CYCLES = 4000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ifu_aligner_if bus ();

    ifu_aligner #(.RESET_PC(RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int n_insts = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] x;
        x = a[31:0] ^ 32'h5bd1_e995;
        x = x * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    function automatic logic [15:0] hw(input logic [63:0] a);
        logic [31:0] w;
        w = mem_word({a[63:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected program order from pc: a marker first if requested, then decoded instructions.
    task automatic push_stream(input logic [63:0] start, input bit mis);
        logic [63:0] pc;
        logic [15:0] p0;
        exp_t e;
        sb.delete();
        pc = start;
        if (mis) begin
            e.pc = pc; e.inst = 32'h0; e.comp = 1'b0; e.mis = 1'b1;
            sb.push_back(e);
        end
        for (int n = 0; n < 200; n++) begin
            p0 = hw(pc);
            e.pc = pc; e.mis = 1'b0;
`ifdef RVC_EN
            if (p0[1:0] != 2'b11) begin
                e.inst = {16'h0, p0}; e.comp = 1'b1;
                pc = pc + 64'd2;
            end else
`endif
            begin
                e.inst = {hw(pc + 64'd2), p0}; e.comp = 1'b0;
                pc = pc + 64'd4;
            end
            sb.push_back(e);
        end
    endtask

    // Memory: one request outstanding, 1..4 cycles to respond.
    initial begin
        bit          acc;
        bit          outstanding;
        int          lat;
        logic [63:0] addr;
        logic [63:0] paddr;
        outstanding = 0; lat = 0; paddr = '0;
        bus.req_ready_i = 1'b0;
        bus.rvalid_i    = 1'b0;
        bus.rdata_i     = 32'h0;
        forever begin
            @(negedge clock);
            acc  = bus.req_valid_o && bus.req_ready_i;
            addr = bus.req_addr_o;
            @(posedge clock);
            #1;
            bus.rvalid_i = 1'b0;
            if (reset) begin
                outstanding = 0;
                bus.req_ready_i = 1'b0;
            end else begin
                if (acc) begin
                    outstanding = 1;
                    paddr = addr;
                    lat = $urandom_range(0, 3);
                end else if (outstanding) begin
                    if (lat == 0) begin
                        bus.rvalid_i = 1'b1;
                        bus.rdata_i  = mem_word(paddr);
                        outstanding  = 0;
                    end else begin
                        lat--;
                    end
                end
                bus.req_ready_i = !outstanding && ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: samples on the falling edge what the next rising edge will see.
    initial begin
        bit          prev_br, prev_hold, prev_req_hold, exp_mark;
        logic [31:0] held_inst;
        logic [63:0] held_pc, held_addr, exp_req;
        exp_t        e;
        prev_br = 0; prev_hold = 0; prev_req_hold = 0;
        held_inst = '0; held_pc = '0; held_addr = '0; exp_req = RESET_PC;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_br = 0; prev_hold = 0; prev_req_hold = 0;
                exp_req = RESET_PC;
            end else begin
                if (prev_br) begin
                    exp_mark = (sb.size() > 0) && sb[0].mis;
                    check(bus.inst_valid_o == exp_mark, "valid_after_branch",
                          64'(bus.inst_valid_o), 64'(exp_mark));
                end
                if (prev_hold) begin
                    check(bus.inst_valid_o && bus.inst_o == held_inst && bus.pc_o == held_pc,
                          "stall_stable_pc", bus.pc_o, held_pc);
                end
                if (prev_req_hold) begin
                    check(bus.req_valid_o && bus.req_addr_o == held_addr,
                          "req_hold", bus.req_addr_o, held_addr);
                end
                if (bus.misaligned_o) begin
                    check(!bus.req_valid_o, "no_req_while_marker", 64'(bus.req_valid_o), 64'd0);
                end
                if (bus.req_valid_o && bus.req_ready_i && !bus.branch_i) begin
                    check(bus.req_addr_o == exp_req, "req_addr", bus.req_addr_o, exp_req);
                    exp_req = exp_req + 64'd4;
                end
                if (bus.branch_i) begin
                    exp_req = {bus.branch_target_i[63:2], 2'b00};
                end
                if (bus.inst_valid_o && bus.inst_ready_i && !bus.branch_i) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "scoreboard_empty", bus.pc_o, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        n_insts++;
                        check(bus.pc_o == e.pc, "pc", bus.pc_o, e.pc);
                        check(bus.inst_o == e.inst, "inst", 64'(bus.inst_o), 64'(e.inst));
                        check(bus.is_compressed_o == e.comp, "is_compressed",
                              64'(bus.is_compressed_o), 64'(e.comp));
                        check(bus.misaligned_o == e.mis, "misaligned",
                              64'(bus.misaligned_o), 64'(e.mis));
                    end
                end
                prev_hold     = bus.inst_valid_o && !bus.inst_ready_i && !bus.branch_i;
                held_inst     = bus.inst_o;
                held_pc       = bus.pc_o;
                prev_req_hold = bus.req_valid_o && !bus.req_ready_i && !bus.branch_i;
                held_addr     = bus.req_addr_o;
                prev_br       = bus.branch_i;
            end
        end
    end

    // Stimulus: decode back-pressure bursts and random redirects.
    initial begin
        int          stall_left, br_gap;
        logic [63:0] tgt;
        reset = 1'b1;
        bus.branch_i        = 1'b0;
        bus.branch_target_i = 64'h0;
        bus.inst_ready_i    = 1'b1;
        push_stream(RESET_PC, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check(!bus.req_valid_o, "reset_req_valid", 64'(bus.req_valid_o), 64'd0);
        check(!bus.inst_valid_o, "reset_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        check(!bus.misaligned_o, "reset_misaligned", 64'(bus.misaligned_o), 64'd0);
        check(bus.req_addr_o == 64'h0, "reset_req_addr", bus.req_addr_o, 64'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check(!bus.req_valid_o, "req_before_first_edge", 64'(bus.req_valid_o), 64'd0);
        @(negedge clock);
        check(bus.req_valid_o && bus.req_addr_o == RESET_PC, "first_req",
              bus.req_addr_o, RESET_PC);

        stall_left = 0;
        br_gap = $urandom_range(20, 120);
        for (int cyc = 0; cyc < RUN_CYCLES; cyc++) begin
            @(posedge clock);
            #2;
            bus.branch_i = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                bus.inst_ready_i = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                stall_left = $urandom_range(1, 10);
                bus.inst_ready_i = 1'b0;
            end else begin
                bus.inst_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (br_gap == 0) begin
                tgt = RESET_PC + 64'($urandom_range(0, 16'hFFFF));
                bus.branch_i        = 1'b1;
                bus.branch_target_i = tgt;
`ifdef RVC_EN
                push_stream({tgt[63:1], 1'b0}, 1'b0);
`else
                push_stream({tgt[63:1], 1'b0}, tgt[1]);
`endif
                br_gap = $urandom_range(3, 120);
            end else begin
                br_gap--;
            end
        end
        @(posedge clock);
        #2;
        bus.branch_i = 1'b0;
        check(n_insts > 300, "progress_insts", 64'(n_insts), 64'd300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
